// File: rtl/w_rom_pkg.sv
`default_nettype none
// ============================================================================
// Module   : w_rom_pkg
// Brief    : Shared W_ROM geometry constants and fetch FSM state type.
// Revision : 1.0
// ============================================================================
package w_rom_pkg;

    localparam int W_ROM_DATA_WIDTH   = 64;
    localparam int W_ROM_DATA_DEPTH   = 512;
    localparam int W_ROM_ADDR_WIDTH   = 9;
    localparam int W_ROM_READ_LATENCY = 1;

    typedef enum logic [1:0] {
        BURN  = 2'd0,
        IDLE  = 2'd1,
        FETCH = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/w_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : w_fetch_buf
// Brief    : Small synchronous FIFO holding ROM words awaiting downstream accept.
// Revision : 1.0
// ============================================================================
module w_fetch_buf #(
    parameter int DATA_WIDTH = 64,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                               clk,
    input  logic                               rst_b,
    input  logic                               push,
    input  logic [DATA_WIDTH-1:0]              push_data,
    input  logic                               pop,
    output logic                               empty,
    output logic [$clog2(BUF_DEPTH+1)-1:0]     count,
    output logic [DATA_WIDTH-1:0]              head
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUF_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(BUF_DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/w_rom_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : w_rom_fetch_ctrl
// Brief    : W_ROM read master: burn-in handshake, then credit-paced burst fetch.
// Revision : 1.0
// ============================================================================
module w_rom_fetch_ctrl
    import w_rom_pkg::*;
#(
    parameter int DATA_WIDTH = W_ROM_DATA_WIDTH,
    parameter int DATA_DEPTH = W_ROM_DATA_DEPTH,
    parameter int ADDR_WIDTH = W_ROM_ADDR_WIDTH,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  burn_in_en,
    input  logic                  burned,
    output logic                  r_en,
    output logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CRED_W = $clog2(BUF_DEPTH + 1);
    localparam int REM_W  = ADDR_WIDTH + 1;
    localparam int LAT    = W_ROM_READ_LATENCY;

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [REM_W-1:0]      remaining_q, remaining_d;
    logic [CRED_W-1:0]     credits_q, credits_d;
    logic [LAT-1:0]        inflight_q, inflight_d;
    logic                  burn_in_en_q, burn_in_en_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  issue;
    logic                  pop;
    logic                  accept;
    logic                  cmd_zero;
    logic                  cmd_too_long;
    logic                  drain_done;
    logic                  buf_empty;
    logic [CRED_W-1:0]     buf_count;

    assign cmd_zero     = (length == '0);
    assign cmd_too_long = (length > REM_W'(DATA_DEPTH));
    assign pop          = !buf_empty && out_ready;

    // A word popped this cycle frees a slot, so it can fund a read issued
    // in the same cycle; this is what keeps 1 word/cycle with two entries.
    assign issue  = (state_q == FETCH) && (remaining_q != '0)
                 && ((credits_q != '0) || pop);
    assign accept = (state_q == IDLE) && start && !cmd_zero && !cmd_too_long;

    // Completion looks ahead one pop so done lands right after the last accept.
    assign drain_done = (inflight_q == '0)
                     && (buf_empty || ((buf_count == CRED_W'(1)) && pop));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= BURN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BURN:    if (burned)                                      state_d = IDLE;
            IDLE:    if (accept)                                      state_d = FETCH;
            FETCH:   if (issue && (remaining_q == REM_W'(1)))         state_d = DRAIN;
            DRAIN:   if (drain_done)                                  state_d = IDLE;
            default:                                                  state_d = BURN;
        endcase
    end

    always_comb begin
        burn_in_en_d = (state_q == BURN) && !burned;
        done_d       = ((state_q == IDLE) && start && cmd_zero)
                    || ((state_q == DRAIN) && drain_done);
        err_d        = (state_q == IDLE) && start && cmd_too_long;
    end

    always_comb begin
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        credits_d   = credits_q;
        inflight_d  = (inflight_q << 1) | LAT'(issue);
        if (accept) begin
            cur_addr_d  = base_addr;
            remaining_d = length;
        end else if (issue) begin
            cur_addr_d  = (cur_addr_q == ADDR_WIDTH'(DATA_DEPTH - 1))
                        ? '0 : cur_addr_q + ADDR_WIDTH'(1);
            remaining_d = remaining_q - REM_W'(1);
        end
        if (issue && !pop) begin
            credits_d = credits_q - CRED_W'(1);
        end else if (!issue && pop) begin
            credits_d = credits_q + CRED_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            credits_q    <= CRED_W'(BUF_DEPTH);
            inflight_q   <= '0;
            burn_in_en_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            credits_q    <= credits_d;
            inflight_q   <= inflight_d;
            burn_in_en_q <= burn_in_en_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    w_fetch_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_b     (rst_b),
        .push      (inflight_q[LAT-1]),
        .push_data (rom_data),
        .pop       (pop),
        .empty     (buf_empty),
        .count     (buf_count),
        .head      (out_data)
    );

    assign burn_in_en = burn_in_en_q;
    assign r_en       = !issue;
    assign addr_in    = cur_addr_q;
    assign out_valid  = !buf_empty;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_w_rom_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_w_rom_fetch_ctrl
// Brief    : Directed self-checking bench with a 1-cycle ROM model and monitors.
// Revision : 1.0
// ============================================================================
module tb_w_rom_fetch_ctrl;

    localparam int DW  = 64;
    localparam int AW  = 9;
    localparam int BUF = 2;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          burn_in_en;
    logic          burned = 1'b0;
    logic          r_en;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] rom_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          done;
    logic          err;

    int n_pass = 0;
    int n_total = 0;

    int            issue_log[$];
    int            issue_cyc[$];
    logic [DW-1:0] rx_log[$];
    int            rx_cyc[$];
    int            cyc = 0;
    int            total_issues = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            outstanding = 0;
    int            credit_viol = 0;
    int            stall_viol = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;

    w_rom_fetch_ctrl dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .burn_in_en (burn_in_en),
        .burned     (burned),
        .r_en       (r_en),
        .addr_in    (addr_in),
        .rom_data   (rom_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_word(input int a);
        return {32'hA500_0000 | 32'(a), 32'(a) * 32'h9E37_79B1};
    endfunction

    always @(posedge clk) begin
        if (!r_en) rom_data <= rom_word(int'(addr_in));
    end

    always @(negedge clk) begin
        cyc++;
        if (rst_b) begin
            if (!r_en) begin
                issue_log.push_back(int'(addr_in));
                issue_cyc.push_back(cyc);
                total_issues++;
                outstanding++;
            end
            if (out_valid && out_ready) begin
                rx_log.push_back(out_data);
                rx_cyc.push_back(cyc);
                outstanding--;
            end
            if (outstanding > BUF) credit_viol++;
            if (stall_prev && (!out_valid || out_data !== stall_data)) stall_viol++;
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            outstanding = 0;
            stall_prev  = 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Releases reset, holds burned low for six burn-in cycles, then raises it.
    task automatic do_burn;
        int en_hi = 0;
        int iss0 = total_issues;
        tick;
        rst_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (burn_in_en === 1'b1) en_hi++;
        end
        n_total++;
        if (busy !== 1'b1) $display("FAIL burn_busy_high got %b want 1", busy); else n_pass++;
        burned = 1'b1;
        tick;
        n_total++;
        if (en_hi !== 6) $display("FAIL burn_en_cycles got %0d want 6", en_hi); else n_pass++;
        n_total++;
        if (burn_in_en !== 1'b0) $display("FAIL burn_en_drop got %b want 0", burn_in_en); else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL burn_busy_fall got %b want 0", busy); else n_pass++;
        n_total++;
        if (total_issues !== iss0) $display("FAIL burn_no_read got %0d want %0d", total_issues, iss0); else n_pass++;
    endtask

    // pat 0: out_ready held high; pat 1: out_ready 1,0,0 repeating.
    task automatic run_burst(input int base, input int len, input int pat,
                             output int n_iss, output int n_rx);
        int k = 0;
        int d0 = done_cnt;
        issue_log.delete(); issue_cyc.delete(); rx_log.delete(); rx_cyc.delete();
        credit_viol = 0; stall_viol = 0;
        out_ready = 1'b1;
        base_addr = AW'(base);
        length    = (AW+1)'(len);
        start     = 1'b1;
        tick;
        start     = 1'b0;
        while (done_cnt == d0 && k < 200) begin
            out_ready = (pat == 0) ? 1'b1 : ((k % 3) == 0);
            tick;
            k++;
        end
        out_ready = 1'b1;
        n_total++;
        if (done_cnt == d0) $display("FAIL burst_done_timeout got 0 want 1"); else n_pass++;
        n_iss = issue_log.size();
        n_rx  = rx_log.size();
        while (issue_log.size() < len) issue_log.push_back(-1);
        while (rx_log.size() < len) begin
            rx_log.push_back('x);
            rx_cyc.push_back(-1);
        end
    endtask

    task automatic test_reset;
        tick; tick;
        n_total++; if (burn_in_en !== 1'b0) $display("FAIL rst_burn_in_en got %b want 0", burn_in_en); else n_pass++;
        n_total++; if (r_en !== 1'b1) $display("FAIL rst_r_en got %b want 1", r_en); else n_pass++;
        n_total++; if (addr_in !== '0) $display("FAIL rst_addr_in got %0d want 0", addr_in); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_data !== '0) $display("FAIL rst_out_data got %h want 0", out_data); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL rst_busy got %b want 1", busy); else n_pass++;
        n_total++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL rst_done_err got %b%b want 00", done, err); else n_pass++;
        do_burn();
    endtask

    task automatic test_basic;
        int n_iss, n_rx;
        run_burst(10, 4, 0, n_iss, n_rx);
        n_total++; if (n_iss !== 4) $display("FAIL basic_issue_count got %0d want 4", n_iss); else n_pass++;
        n_total++; if (n_rx !== 4) $display("FAIL basic_rx_count got %0d want 4", n_rx); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (issue_log[i] !== 10 + i) $display("FAIL basic_addr[%0d] got %0d want %0d", i, issue_log[i], 10 + i); else n_pass++;
            n_total++;
            if (rx_log[i] !== rom_word(10 + i)) $display("FAIL basic_data[%0d] got %h want %h", i, rx_log[i], rom_word(10 + i)); else n_pass++;
        end
        n_total++;
        if (issue_cyc[3] - issue_cyc[0] !== 3) $display("FAIL basic_issue_b2b got %0d want 3", issue_cyc[3] - issue_cyc[0]); else n_pass++;
        n_total++;
        if (rx_cyc[0] - issue_cyc[0] !== 2) $display("FAIL basic_first_latency got %0d want 2", rx_cyc[0] - issue_cyc[0]); else n_pass++;
        n_total++;
        if (rx_cyc[3] - rx_cyc[0] !== 3) $display("FAIL basic_rx_b2b got %0d want 3", rx_cyc[3] - rx_cyc[0]); else n_pass++;
        n_total++;
        if (done_cyc - rx_cyc[3] !== 1) $display("FAIL basic_done_timing got %0d want 1", done_cyc - rx_cyc[3]); else n_pass++;
    endtask

    task automatic test_wrap;
        int n_iss, n_rx;
        int exp_a[4] = '{510, 511, 0, 1};
        run_burst(510, 4, 0, n_iss, n_rx);
        n_total++; if (n_rx !== 4) $display("FAIL wrap_rx_count got %0d want 4", n_rx); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (issue_log[i] !== exp_a[i]) $display("FAIL wrap_addr[%0d] got %0d want %0d", i, issue_log[i], exp_a[i]); else n_pass++;
            n_total++;
            if (rx_log[i] !== rom_word(exp_a[i])) $display("FAIL wrap_data[%0d] got %h want %h", i, rx_log[i], rom_word(exp_a[i])); else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        int n_iss, n_rx;
        run_burst(0, 8, 1, n_iss, n_rx);
        n_total++; if (n_rx !== 8) $display("FAIL bp_rx_count got %0d want 8", n_rx); else n_pass++;
        n_total++; if (n_iss !== 8) $display("FAIL bp_issue_count got %0d want 8", n_iss); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (rx_log[i] !== rom_word(i)) $display("FAIL bp_data[%0d] got %h want %h", i, rx_log[i], rom_word(i)); else n_pass++;
        end
        n_total++; if (credit_viol !== 0) $display("FAIL bp_credit_overrun got %0d want 0", credit_viol); else n_pass++;
        n_total++; if (stall_viol !== 0) $display("FAIL bp_stall_stable got %0d want 0", stall_viol); else n_pass++;
    endtask

    task automatic test_reject;
        int iss0 = total_issues;
        base_addr = AW'(5);
        length    = '0;
        start     = 1'b1;
        tick;
        start     = 1'b0;
        n_total++; if (done !== 1'b1) $display("FAIL zero_done got %b want 1", done); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL zero_err got %b want 0", err); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL zero_busy got %b want 0", busy); else n_pass++;
        tick;
        n_total++; if (done !== 1'b0) $display("FAIL zero_done_pulse got %b want 0", done); else n_pass++;
        length = (AW+1)'(513);
        start  = 1'b1;
        tick;
        start  = 1'b0;
        n_total++; if (err !== 1'b1) $display("FAIL long_err got %b want 1", err); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL long_done got %b want 0", done); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL long_busy got %b want 0", busy); else n_pass++;
        tick;
        n_total++; if (err !== 1'b0) $display("FAIL long_err_pulse got %b want 0", err); else n_pass++;
        n_total++; if (total_issues !== iss0) $display("FAIL reject_no_read got %0d want %0d", total_issues, iss0); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int k = 0;
        int n_iss, n_rx;
        rx_log.delete();
        out_ready = 1'b1;
        base_addr = '0;
        length    = (AW+1)'(6);
        start     = 1'b1;
        tick;
        start     = 1'b0;
        while (rx_log.size() < 3 && k < 50) begin
            tick;
            k++;
        end
        n_total++;
        if (rx_log.size() < 3) $display("FAIL mid_progress got %0d want 3", rx_log.size()); else n_pass++;
        rst_b  = 1'b0;
        burned = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (r_en !== 1'b1) $display("FAIL mid_r_en got %b want 1", r_en); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL mid_busy got %b want 1", busy); else n_pass++;
        do_burn();
        run_burst(0, 2, 0, n_iss, n_rx);
        n_total++; if (n_rx !== 2) $display("FAIL post_rx_count got %0d want 2", n_rx); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if (rx_log[i] !== rom_word(i)) $display("FAIL post_data[%0d] got %h want %h", i, rx_log[i], rom_word(i)); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_reject();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
